mole_game_controller: RTL and testbench
=======================================

// Module: mole_game_controller
// PURPOSE
//  Game FSM for whack-a-mole. Consumes the debounced start and mole-button pulses and the
//  1Hz divider output. Drives the one-hot mole LEDs, a saturating score, the seconds-left
//  count and game status flags, which feed the display path. Single clock domain (100MHz).
// PARAMETERS
//  NUM_MOLES      5           number of moles/buttons; legal range 4..8
//  GAME_SECONDS   30          game length in secondTick rising edges; 1..2^TIME_WIDTH-1
//  MOLE_UP_TICKS  2           tick rising edges a mole stays lit before a miss; >=1
//  GAP_CYCLES     25_000_000  clock cycles of all-dark gap between moles; >=1
//  SCORE_WIDTH    8           score width; score saturates at 2^SCORE_WIDTH-1
//  TIME_WIDTH     7           timeLeft width
//  LFSR_SEED      16'hACE1    nonzero LFSR reset value
// PORTS
//  clock        in   1            system clock, 100MHz
//  reset        in   1            synchronous, active-low reset
//  startPulse   in   1            debounced start, one-cycle pulse
//  moleHit      in   NUM_MOLES    debounced mole buttons, one-cycle pulses
//  secondTick   in   1            1Hz divider output, level or strobe; edge-detected here
//  moleLED      out  NUM_MOLES    one-hot lit mole, or all zero
//  score        out  SCORE_WIDTH  current score
//  timeLeft     out  TIME_WIDTH   seconds remaining
//  gameActive   out  1            high in SPAWN/MOLE_UP/GAP
//  gameOver     out  1            high in OVER
// BEHAVIOUR
//  Reset (reset==0 at a clock edge):
//   state=IDLE, moleLED=0, score=0, timeLeft=GAME_SECONDS, gameActive=0, gameOver=0,
//   tickPrev=0, lfsr=LFSR_SEED. Reset mid-game aborts immediately; no other priority applies.
//  tickRise = secondTick & ~tickPrev; tickPrev is registered every cycle.
//  LFSR: 16-bit Galois, x^16+x^14+x^13+x^11+1. Free-runs every cycle in all states.
//   r = lfsr[2:0]; idx = (r >= NUM_MOLES) ? r - NUM_MOLES : r.
//  States:
//   IDLE/OVER: startPulse -> score=0, timeLeft=GAME_SECONDS, go SPAWN. Other inputs ignored.
//   SPAWN (1 cycle): moleLED = 1<<idx; upCnt = MOLE_UP_TICKS; go MOLE_UP.
//   MOLE_UP:
//    - hit = |(moleHit & moleLED) -> score+1 (saturating), moleLED=0, gapCnt=0, go GAP.
//    - else if moleHit != 0 (wrong button only) -> score-1, saturating at 0; stay.
//    - else if tickRise and upCnt==1 -> miss: moleLED=0, go GAP; if tickRise and upCnt>1,
//      upCnt-1.
//    - Correct and wrong buttons in the same cycle count as a hit only.
//    - A hit beats tickRise in the same cycle.
//   GAP: moleLED=0. gapCnt counts to GAP_CYCLES-1, then go SPAWN.
//  Global timer, active states only: tickRise -> timeLeft-1. When timeLeft goes 1->0:
//   - next state = OVER, overriding any local transition; moleLED=0.
//   - A hit in the same cycle is still scored.
//  Flags are registered with state: gameActive = state in {SPAWN,MOLE_UP,GAP};
//   gameOver = (state==OVER).
//  startPulse during an active game is ignored.
//  moleLED is never more than one-hot.
//  All outputs are registered. A button response is visible on the edge after the pulse.
// TESTING
//  Sim params: GAME_SECONDS=3, MOLE_UP_TICKS=2, GAP_CYCLES=4, SCORE_WIDTH=2.
//  T1 Reset: hold reset=0 for 2 cycles
//     -> moleLED=0, score=0, timeLeft=3, gameActive=0, gameOver=0.
//  T2 Hit: startPulse, then pulse the button matching the lit LED
//     -> next edge score=1, moleLED=0; after 4 cycles a new one-hot LED lights.
//  T3 Miss: start, give no presses, 2 secondTick rises
//     -> LED clears on the 2nd rise; score stays 0; timeLeft=1.
//  T4 Wrong button: non-lit button at score=0 -> score stays 0.
//     Hit, then wrong button -> score 1 then 0. Lit+wrong together -> +1.
//  T5 Timeout and restart: 3 tick rises
//     -> gameOver=1, moleLED=0, timeLeft=0. Mid-game start ignored.
//     Start in OVER -> score=0, timeLeft=3.
//  T6 Saturation/reset: 4 hits -> score stays 3. reset=0 mid-MOLE_UP
//     -> next edge all reset values.

Source files
------------

// File: rtl/mole_game_controller.sv
// Whack-a-mole game sequencer: spawns one pseudo-random mole at a time, scores hits and
// wrong presses, and runs the per-second game clock down to game over.
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | after reset, waiting for start
// SPAWN   | one cycle, lights a mole chosen from the LFSR
// MOLE_UP | mole lit, waiting for a press or tick expiry
// GAP     | all moles dark between spawns
// OVER    | game clock expired, waiting for restart
module mole_game_controller #(
    parameter int          NUM_MOLES     = 5,
    parameter int          GAME_SECONDS  = 30,
    parameter int          MOLE_UP_TICKS = 2,
    parameter int          GAP_CYCLES    = 25_000_000,
    parameter int          SCORE_WIDTH   = 8,
    parameter int          TIME_WIDTH    = 7,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   startPulse,
    input  logic [NUM_MOLES-1:0]   moleHit,
    input  logic                   secondTick,
    output logic [NUM_MOLES-1:0]   moleLED,
    output logic [SCORE_WIDTH-1:0] score,
    output logic [TIME_WIDTH-1:0]  timeLeft,
    output logic                   gameActive,
    output logic                   gameOver
);

    localparam int UP_W  = $clog2(MOLE_UP_TICKS + 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SPAWN   = 3'd1,
        MOLE_UP = 3'd2,
        GAP     = 3'd3,
        OVER    = 3'd4
    } state_t;

    state_t                 state, state_next;
    logic [NUM_MOLES-1:0]   led_next;
    logic [SCORE_WIDTH-1:0] score_next;
    logic [TIME_WIDTH-1:0]  time_next;
    logic [UP_W-1:0]        up_cnt, up_next;
    logic [GAP_W-1:0]       gap_cnt, gap_next;
    logic [15:0]            lfsr, lfsr_next;
    logic                   tick_prev;
    logic                   tick_rise;
    logic                   hit;
    logic                   wrong;
    logic                   active;
    logic [3:0]             rnd;
    logic [3:0]             idx;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            moleLED    <= '0;
            score      <= '0;
            timeLeft   <= TIME_WIDTH'(GAME_SECONDS);
            up_cnt     <= '0;
            gap_cnt    <= '0;
            lfsr       <= LFSR_SEED;
            tick_prev  <= 1'b0;
            gameActive <= 1'b0;
            gameOver   <= 1'b0;
        end else begin
            state      <= state_next;
            moleLED    <= led_next;
            score      <= score_next;
            timeLeft   <= time_next;
            up_cnt     <= up_next;
            gap_cnt    <= gap_next;
            lfsr       <= lfsr_next;
            tick_prev  <= secondTick;
            gameActive <= (state_next == SPAWN) || (state_next == MOLE_UP) || (state_next == GAP);
            gameOver   <= (state_next == OVER);
        end
    end

    always_comb begin
        state_next = state;
        led_next   = moleLED;
        score_next = score;
        time_next  = timeLeft;
        up_next    = up_cnt;
        gap_next   = gap_cnt;

        tick_rise = secondTick & ~tick_prev;
        hit       = |(moleHit & moleLED);
        wrong     = |moleHit;
        active    = (state == SPAWN) || (state == MOLE_UP) || (state == GAP);

        // Galois form of x^16+x^14+x^13+x^11+1, shifting toward bit 0
        lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        rnd       = {1'b0, lfsr[2:0]};
        idx       = (rnd >= 4'(NUM_MOLES)) ? rnd - 4'(NUM_MOLES) : rnd;

        case (state)
            IDLE, OVER: begin
                if (startPulse) begin
                    score_next = '0;
                    time_next  = TIME_WIDTH'(GAME_SECONDS);
                    state_next = SPAWN;
                end
            end
            SPAWN: begin
                led_next   = NUM_MOLES'(1) << idx;
                up_next    = UP_W'(MOLE_UP_TICKS);
                state_next = MOLE_UP;
            end
            MOLE_UP: begin
                if (hit) begin
                    score_next = (score == '1) ? score : score + 1'b1;
                    led_next   = '0;
                    gap_next   = '0;
                    state_next = GAP;
                end else if (wrong) begin
                    score_next = (score == '0) ? score : score - 1'b1;
                end else if (tick_rise) begin
                    if (up_cnt == UP_W'(1)) begin
                        led_next   = '0;
                        gap_next   = '0;
                        state_next = GAP;
                    end else begin
                        up_next = up_cnt - 1'b1;
                    end
                end
            end
            GAP: begin
                led_next = '0;
                if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                    state_next = SPAWN;
                end else begin
                    gap_next = gap_cnt + 1'b1;
                end
            end
            default: begin
                led_next   = '0;
                state_next = IDLE;
            end
        endcase

        // Game clock expiry overrides whatever the local transition chose
        if (active && tick_rise && (timeLeft != '0)) begin
            time_next = timeLeft - 1'b1;
            if (timeLeft == TIME_WIDTH'(1)) begin
                state_next = OVER;
                led_next   = '0;
            end
        end
    end

endmodule

// File: tb/tb_mole_game_controller.sv
// Bench for mole_game_controller: directed game scenarios plus random play, all checked
// every cycle against a behavioural game model.
module tb_mole_game_controller;

    localparam int NM   = 5;
    localparam int GS   = 3;
    localparam int UT   = 2;
    localparam int GC   = 4;
    localparam int SW   = 2;
    localparam int TW   = 7;
    localparam int SMAX = (1 << SW) - 1;
    localparam int SEED = 16'hACE1;

    logic          clock = 1'b0;
    logic          reset;
    logic          startPulse;
    logic [NM-1:0] moleHit;
    logic          secondTick;
    logic [NM-1:0] moleLED;
    logic [SW-1:0] score;
    logic [TW-1:0] timeLeft;
    logic          gameActive;
    logic          gameOver;

    int tests = 0;
    int fails = 0;

    // game model
    bit m_play = 0, m_over = 0, m_spawn = 0, m_in_gap = 0, m_tprev = 0;
    int m_lit = -1, m_ups = 0, m_gap = 0, m_score = 0, m_time = GS, m_lfsr = SEED;

    always #5 clock = ~clock;

    mole_game_controller #(
        .NUM_MOLES(NM), .GAME_SECONDS(GS), .MOLE_UP_TICKS(UT), .GAP_CYCLES(GC),
        .SCORE_WIDTH(SW), .TIME_WIDTH(TW), .LFSR_SEED(16'hACE1)
    ) dut (
        .clock(clock), .reset(reset), .startPulse(startPulse), .moleHit(moleHit),
        .secondTick(secondTick), .moleLED(moleLED), .score(score), .timeLeft(timeLeft),
        .gameActive(gameActive), .gameOver(gameOver)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            if (fails <= 30)
                $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_step();
        bit rise, was_play;
        int r;
        rise     = secondTick && !m_tprev;
        was_play = m_play;
        if (!reset) begin
            m_play = 0; m_over = 0; m_spawn = 0; m_in_gap = 0; m_lit = -1;
            m_score = 0; m_time = GS; m_tprev = 0; m_lfsr = SEED;
            return;
        end
        if (!m_play) begin
            if (startPulse) begin
                m_score = 0; m_time = GS; m_play = 1; m_over = 0; m_spawn = 1; m_lit = -1;
            end
        end else if (m_spawn) begin
            r       = m_lfsr & 7;
            m_lit   = (r >= NM) ? r - NM : r;
            m_ups   = UT;
            m_spawn = 0;
        end else if (m_in_gap) begin
            if (m_gap == GC - 1) begin
                m_in_gap = 0; m_spawn = 1;
            end else begin
                m_gap++;
            end
        end else if (moleHit[m_lit]) begin
            m_score  = (m_score < SMAX) ? m_score + 1 : SMAX;
            m_lit    = -1; m_in_gap = 1; m_gap = 0;
        end else if (moleHit != 0) begin
            m_score = (m_score > 0) ? m_score - 1 : 0;
        end else if (rise) begin
            if (m_ups == 1) begin
                m_lit = -1; m_in_gap = 1; m_gap = 0;
            end else begin
                m_ups--;
            end
        end
        if (was_play && rise) begin
            m_time--;
            if (m_time == 0) begin
                m_play = 0; m_over = 1; m_lit = -1; m_spawn = 0; m_in_gap = 0;
            end
        end
        m_lfsr  = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? 'hB400 : 0);
        m_tprev = secondTick;
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        check_eq("moleLED", 32'(moleLED), (m_lit >= 0) ? (32'd1 << m_lit) : 32'd0);
        check_eq("score", 32'(score), 32'(m_score));
        check_eq("timeLeft", 32'(timeLeft), 32'(m_time));
        check_eq("gameActive", 32'(gameActive), 32'(m_play));
        check_eq("gameOver", 32'(gameOver), 32'(m_over));
        startPulse = 1'b0;
        moleHit    = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0; secondTick = 1'b0;
        cycle(); cycle();
        reset = 1'b1;
    endtask

    task automatic wait_lit(input string tag);
        for (int i = 0; i < 20 && m_lit < 0; i++) cycle();
        check_eq(tag, 32'(m_lit >= 0), 32'd1);
    endtask

    task automatic tick_rise();
        secondTick = 1'b1; cycle();
        secondTick = 1'b0; cycle();
    endtask

    initial begin
        int n;
        reset = 1'b0; startPulse = 1'b0; moleHit = '0; secondTick = 1'b0;

        // T1 reset values
        do_reset();
        check_eq("t1_led", 32'(moleLED), 0);
        check_eq("t1_score", 32'(score), 0);
        check_eq("t1_time", 32'(timeLeft), GS);
        check_eq("t1_active", 32'(gameActive), 0);
        check_eq("t1_over", 32'(gameOver), 0);

        // T2 hit then respawn after the gap
        startPulse = 1'b1; cycle();
        check_eq("t2_active", 32'(gameActive), 1);
        cycle();
        check_eq("t2_onehot", 32'($countones(moleLED)), 1);
        moleHit = moleLED; cycle();
        check_eq("t2_score", 32'(score), 1);
        check_eq("t2_led_off", 32'(moleLED), 0);
        n = 0;
        while (moleLED == '0 && n < 20) begin cycle(); n++; end
        check_eq("t2_relit_delay", 32'(n), GC + 1);
        check_eq("t2_relit_onehot", 32'($countones(moleLED)), 1);

        // T3 miss after two rises
        do_reset();
        startPulse = 1'b1; cycle(); cycle();
        secondTick = 1'b1; cycle();
        secondTick = 1'b0; cycle();
        check_eq("t3_still_lit", 32'($countones(moleLED)), 1);
        secondTick = 1'b1; cycle();
        check_eq("t3_miss_led", 32'(moleLED), 0);
        check_eq("t3_score", 32'(score), 0);
        check_eq("t3_time", 32'(timeLeft), 1);
        secondTick = 1'b0; cycle();

        // T4 wrong button handling
        do_reset();
        startPulse = 1'b1; cycle(); cycle();
        moleHit = NM'(1) << ((m_lit + 1) % NM); cycle();
        check_eq("t4_wrong_at0", 32'(score), 0);
        moleHit = NM'(1) << m_lit; cycle();
        check_eq("t4_hit", 32'(score), 1);
        wait_lit("t4_wait1");
        moleHit = NM'(1) << ((m_lit + 2) % NM); cycle();
        check_eq("t4_wrong", 32'(score), 0);
        moleHit = (NM'(1) << m_lit) | (NM'(1) << ((m_lit + 3) % NM)); cycle();
        check_eq("t4_both", 32'(score), 1);

        // T5 timeout, ignored mid-game start, restart
        startPulse = 1'b1; cycle();
        check_eq("t5_start_ignored_score", 32'(score), 1);
        check_eq("t5_start_ignored_time", 32'(timeLeft), GS);
        tick_rise(); tick_rise();
        secondTick = 1'b1; cycle();
        check_eq("t5_over", 32'(gameOver), 1);
        check_eq("t5_over_led", 32'(moleLED), 0);
        check_eq("t5_over_time", 32'(timeLeft), 0);
        check_eq("t5_over_active", 32'(gameActive), 0);
        startPulse = 1'b1; cycle();
        check_eq("t5_restart_score", 32'(score), 0);
        check_eq("t5_restart_time", 32'(timeLeft), GS);
        check_eq("t5_restart_active", 32'(gameActive), 1);
        secondTick = 1'b0; cycle();

        // T6 saturation and mid-game reset
        do_reset();
        startPulse = 1'b1; cycle();
        for (int k = 0; k < 4; k++) begin
            wait_lit("t6_wait");
            moleHit = NM'(1) << m_lit; cycle();
        end
        check_eq("t6_sat", 32'(score), SMAX);
        wait_lit("t6_wait_up");
        reset = 1'b0; cycle(); reset = 1'b1;
        check_eq("t6_rst_led", 32'(moleLED), 0);
        check_eq("t6_rst_score", 32'(score), 0);
        check_eq("t6_rst_time", 32'(timeLeft), GS);
        check_eq("t6_rst_active", 32'(gameActive), 0);

        // random play
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 299) != 0);
            startPulse = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 7) == 0) secondTick = ~secondTick;
            if ($urandom_range(0, 2) == 0) begin
                if (m_lit >= 0 && $urandom_range(0, 1) == 1)
                    moleHit = (NM'(1) << m_lit) | (($urandom_range(0, 3) == 0) ? NM'($urandom_range(0, 31)) : NM'(0));
                else
                    moleHit = NM'($urandom_range(0, 31));
            end
            cycle();
        end
        reset = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
